// File: rtl/baud_tick_gen.sv
// Fractional baud tick generator.
//
// Divides CLK down to an oversample tick (ovsTick) whose average period is
// baud_divint + baud_divfrac / 2^FRAC_W clocks. A fractional accumulator
// stretches individual periods by one clock when it overflows. OVS oversample
// ticks make one bit. midTick marks the bit centre and bitTick marks the bit
// boundary.
//
// A new divisor is offered through a valid/ready handshake and held in a
// pending slot. It is applied at once while the generator is disabled.
// While the generator runs, it is applied only on a bit boundary, so a bit
// never mixes two rates.
//
// Ports:
//   CLK          sole clock, rising edge
//   RSTn         synchronous active-low reset
//   enable       1 = generator runs, 0 = counters held idle
//   cfg_valid    new divisor offered
//   cfg_ready    pending slot free (transfer = cfg_valid & cfg_ready)
//   baud_divint  integer clocks per oversample tick (0 behaves as 1)
//   baud_divfrac fractional clocks per oversample tick, in units of 2^-FRAC_W
//   ovsTick      one-clock pulse per oversample period
//   midTick      one-clock pulse at the bit centre
//   bitTick      one-clock pulse at the bit boundary
//   cfg_busy     a captured divisor is waiting to be applied
module baud_tick_gen #(
    parameter int unsigned INT_W  = 16,
    parameter int unsigned FRAC_W = 6,
    parameter int unsigned OVS    = 16
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [INT_W-1:0]  baud_divint,
    input  logic [FRAC_W-1:0] baud_divfrac,
    output logic              ovsTick,
    output logic              midTick,
    output logic              bitTick,
    output logic              cfg_busy
);

    localparam int unsigned       OVS_W    = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [OVS_W-1:0]  OVS_LAST = OVS_W'(OVS - 1);
    localparam logic [OVS_W-1:0]  OVS_MID  = OVS_W'(OVS / 2 - 1);
    localparam logic [OVS_W-1:0]  OVS_ONE  = OVS_W'(1);
    localparam logic [INT_W:0]    CNT_ONE  = {{INT_W{1'b0}}, 1'b1};

    // A zero integer divisor behaves as 1, giving one tick per clock.
    function automatic logic [INT_W:0] eff_div(input logic [INT_W-1:0] div);
        eff_div = (div == '0) ? CNT_ONE : {1'b0, div};
    endfunction

    logic [INT_W:0]    int_count_q, int_count_d;
    logic [INT_W:0]    target_q, target_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [OVS_W-1:0]  ovs_cnt_q, ovs_cnt_d;
    logic [INT_W-1:0]  act_int_q, act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [INT_W-1:0]  pend_int_q, pend_int_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic              pend_q, pend_d;
    logic              ovs_tick_q, ovs_tick_d;
    logic              mid_tick_q, mid_tick_d;
    logic              bit_tick_q, bit_tick_d;

    logic [FRAC_W:0]   sum;
    logic              bit_end;

    always_comb begin
        int_count_d = int_count_q;
        target_d    = target_q;
        acc_d       = acc_q;
        ovs_cnt_d   = ovs_cnt_q;
        act_int_d   = act_int_q;
        act_frac_d  = act_frac_q;
        pend_int_d  = pend_int_q;
        pend_frac_d = pend_frac_q;
        pend_d      = pend_q;
        ovs_tick_d  = 1'b0;
        mid_tick_d  = 1'b0;
        bit_tick_d  = 1'b0;
        sum         = '0;
        bit_end     = 1'b0;

        // Capture and apply never collide: capture needs the slot empty,
        // apply needs it full.
        if (cfg_valid && !pend_q) begin
            pend_int_d  = baud_divint;
            pend_frac_d = baud_divfrac;
            pend_d      = 1'b1;
        end

        if (!enable) begin
            int_count_d = CNT_ONE;
            acc_d       = '0;
            ovs_cnt_d   = '0;
            if (pend_q) begin
                act_int_d  = pend_int_q;
                act_frac_d = pend_frac_q;
                pend_d     = 1'b0;
                target_d   = eff_div(pend_int_q);
            end else begin
                target_d = eff_div(act_int_q);
            end
        end else if (int_count_q >= target_q) begin
            bit_end     = (ovs_cnt_q == OVS_LAST);
            int_count_d = CNT_ONE;
            ovs_tick_d  = 1'b1;
            mid_tick_d  = (ovs_cnt_q == OVS_MID);
            bit_tick_d  = bit_end;
            ovs_cnt_d   = bit_end ? '0 : ovs_cnt_q + OVS_ONE;
            // Accumulator overflow lengthens the next period by one clock.
            sum         = {1'b0, acc_q} + {1'b0, act_frac_q};
            acc_d       = sum[FRAC_W-1:0];
            target_d    = eff_div(act_int_q) + {{INT_W{1'b0}}, sum[FRAC_W]};
            // The new divisor starts with a clean fraction on the bit boundary.
            if (bit_end && pend_q) begin
                act_int_d  = pend_int_q;
                act_frac_d = pend_frac_q;
                pend_d     = 1'b0;
                acc_d      = '0;
                target_d   = eff_div(pend_int_q);
            end
        end else begin
            int_count_d = int_count_q + CNT_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            int_count_q <= CNT_ONE;
            target_q    <= CNT_ONE;
            acc_q       <= '0;
            ovs_cnt_q   <= '0;
            act_int_q   <= {{(INT_W-1){1'b0}}, 1'b1};
            act_frac_q  <= '0;
            pend_int_q  <= '0;
            pend_frac_q <= '0;
            pend_q      <= 1'b0;
            ovs_tick_q  <= 1'b0;
            mid_tick_q  <= 1'b0;
            bit_tick_q  <= 1'b0;
        end else begin
            int_count_q <= int_count_d;
            target_q    <= target_d;
            acc_q       <= acc_d;
            ovs_cnt_q   <= ovs_cnt_d;
            act_int_q   <= act_int_d;
            act_frac_q  <= act_frac_d;
            pend_int_q  <= pend_int_d;
            pend_frac_q <= pend_frac_d;
            pend_q      <= pend_d;
            ovs_tick_q  <= ovs_tick_d;
            mid_tick_q  <= mid_tick_d;
            bit_tick_q  <= bit_tick_d;
        end
    end

    assign cfg_ready = ~pend_q;
    assign cfg_busy  = pend_q;
    assign ovsTick   = ovs_tick_q;
    assign midTick   = mid_tick_q;
    assign bitTick   = bit_tick_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen (INT_W=16, FRAC_W=6, OVS=16).
module tb_baud_tick_gen;

    logic        CLK;
    logic        RSTn;
    logic        enable;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] baud_divint;
    logic [5:0]  baud_divfrac;
    logic        ovsTick;
    logic        midTick;
    logic        bitTick;
    logic        cfg_busy;

    baud_tick_gen #(
        .INT_W  (16),
        .FRAC_W (6),
        .OVS    (16)
    ) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .enable       (enable),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .baud_divint  (baud_divint),
        .baud_divfrac (baud_divfrac),
        .ovsTick      (ovsTick),
        .midTick      (midTick),
        .bitTick      (bitTick),
        .cfg_busy     (cfg_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int q_ovs[$];
    int q_mid[$];
    int q_bit[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // Run n clocks, recording the cycle of every tick.
    task automatic run(input int n);
        q_ovs.delete();
        q_mid.delete();
        q_bit.delete();
        for (int i = 0; i < n; i++) begin
            step();
            if (ovsTick) q_ovs.push_back(cyc);
            if (midTick) q_mid.push_back(cyc);
            if (bitTick) q_bit.push_back(cyc);
        end
    endtask

    // sel 0: wait for ovsTick, sel 1: wait for bitTick (bounded).
    task automatic wait_for(input int sel, input int limit, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < limit; i++) begin
            step();
            if ((sel == 0 && ovsTick) || (sel == 1 && bitTick)) begin
                seen = 1;
                break;
            end
        end
        check(tag, seen, 1);
    endtask

    // Load a divisor with the generator disabled.
    task automatic cfg(input int di, input int df);
        enable       = 1'b0;
        cfg_valid    = 1'b1;
        baud_divint  = 16'(di);
        baud_divfrac = 6'(df);
        step();
        cfg_valid = 1'b0;
        step();
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t_en;
        int t_b;
        int t_b2;
        int bad;
        int drops;
        int found;

        RSTn         = 1'b0;
        enable       = 1'b0;
        cfg_valid    = 1'b0;
        baud_divint  = '0;
        baud_divfrac = '0;
        step();
        step();
        check("rst_ovs", ovsTick, 0);
        check("rst_mid", midTick, 0);
        check("rst_bit", bitTick, 0);
        check("rst_ready", cfg_ready, 1);
        check("rst_busy", cfg_busy, 0);
        RSTn = 1'b1;
        step();

        // int=4, frac=0: ovsTick every 4, midTick at 32, bitTick every 64.
        cfg_valid   = 1'b1;
        baud_divint = 16'd4;
        step();
        cfg_valid = 1'b0;
        check("a_busy_captured", cfg_busy, 1);
        check("a_ready_captured", cfg_ready, 0);
        step();
        check("a_busy_applied_idle", cfg_busy, 0);
        enable = 1'b1;
        t_en   = cyc;
        run(140);
        check("a_first_ovs", q_ovs[0] - t_en, 4);
        bad = 0;
        for (int i = 1; i < q_ovs.size(); i++)
            if (q_ovs[i] - q_ovs[i-1] != 4) bad++;
        check("a_ovs_period_errs", bad, 0);
        check("a_ovs_count", q_ovs.size(), 35);
        check("a_mid_count", q_mid.size(), 2);
        check("a_first_mid", q_mid[0] - t_en, 32);
        check("a_bit_count", q_bit.size(), 2);
        check("a_first_bit", q_bit[0] - t_en, 64);
        check("a_bit_period", q_bit[1] - q_bit[0], 64);
        enable = 1'b0;
        run(10);
        check("a_idle_ticks", q_ovs.size() + q_mid.size() + q_bit.size(), 0);

        // int=2, frac=32: periods 2,2,3,2,3,... and 80 clocks per 32 ticks.
        cfg(2, 32);
        enable = 1'b1;
        t_en   = cyc;
        run(200);
        check("b_ovs_enough", (q_ovs.size() >= 34) ? 1 : 0, 1);
        check("b_ovs0", q_ovs[0] - t_en, 2);
        check("b_ovs1", q_ovs[1] - t_en, 4);
        check("b_ovs2", q_ovs[2] - t_en, 7);
        check("b_ovs3", q_ovs[3] - t_en, 9);
        check("b_span32_a", q_ovs[32] - q_ovs[0], 80);
        check("b_span32_b", q_ovs[33] - q_ovs[1], 80);
        bad = 0;
        for (int i = 1; i < q_ovs.size(); i++)
            if (q_ovs[i] - q_ovs[i-1] > 3 || q_ovs[i] - q_ovs[i-1] < 2) bad++;
        check("b_period_range_errs", bad, 0);

        // int=0 behaves as 1: ovsTick every clock, bitTick every 16.
        cfg(0, 0);
        enable = 1'b1;
        t_en   = cyc;
        run(40);
        check("c_ovs_count", q_ovs.size(), 40);
        check("c_first_ovs", q_ovs[0] - t_en, 1);
        check("c_first_mid", q_mid[0] - t_en, 8);
        check("c_first_bit", q_bit[0] - t_en, 16);
        check("c_second_bit", q_bit[1] - t_en, 32);

        // Running int=4, switch to int=8 mid-bit.
        cfg(4, 0);
        enable = 1'b1;
        t_en   = cyc;
        for (int i = 0; i < 20; i++) step();
        cfg_valid   = 1'b1;
        baud_divint = 16'd8;
        step();
        cfg_valid = 1'b0;
        check("d_busy_set", cfg_busy, 1);
        check("d_ready_clr", cfg_ready, 0);
        drops = 0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bitTick) begin
                found = 1;
                break;
            end
            if (!cfg_busy) drops++;
        end
        check("d_bit_found", found, 1);
        check("d_busy_held", drops, 0);
        check("d_bit_time", cyc - t_en, 64);
        check("d_busy_clr", cfg_busy, 0);
        check("d_ready_set", cfg_ready, 1);
        t_b = cyc;
        wait_for(0, 50, "d_ovs_seen");
        check("d_first_new_period", cyc - t_b, 8);

        // Transfer registered on the same edge as bitTick: applies a bit later.
        while (cyc < t_b + 127) step();
        cfg_valid   = 1'b1;
        baud_divint = 16'd3;
        step();
        cfg_valid = 1'b0;
        check("e_bit_coincident", bitTick, 1);
        check("e_busy_pending", cfg_busy, 1);
        t_b2 = cyc;
        wait_for(0, 50, "e_ovs_seen");
        check("e_old_period_kept", cyc - t_b2, 8);
        wait_for(1, 300, "e_bit_seen");
        check("e_next_bit_time", cyc - t_b2, 128);
        check("e_busy_applied", cfg_busy, 0);
        t_b2 = cyc;
        wait_for(0, 50, "e_ovs_new_seen");
        check("e_new_period", cyc - t_b2, 3);

        // Reset during a run with a divisor pending.
        step();
        cfg_valid   = 1'b1;
        baud_divint = 16'd5;
        step();
        cfg_valid = 1'b0;
        check("f_busy_before_rst", cfg_busy, 1);
        RSTn = 1'b0;
        step();
        check("f_rst_ticks", {29'd0, ovsTick, midTick, bitTick}, 0);
        check("f_rst_busy", cfg_busy, 0);
        check("f_rst_ready", cfg_ready, 1);
        RSTn = 1'b1;
        step();
        check("f_int1_tick", ovsTick, 1);
        t_b = cyc;
        wait_for(1, 40, "f_bit_seen");
        check("f_bit_after_rst", cyc - t_b, 15);
        enable = 1'b0;
        run(10);
        check("f_idle_ticks", q_ovs.size() + q_mid.size() + q_bit.size(), 0);
        // Abort a bit part-way; the next bit must be a full 16 ticks.
        enable = 1'b1;
        for (int i = 0; i < 5; i++) step();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) step();
        enable = 1'b1;
        t_en   = cyc;
        wait_for(1, 40, "f_bit2_seen");
        check("f_full_bit_after_abort", cyc - t_en, 16);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 Parameter INT_W, default 16: width of the integer divisor.
REQ-002 Parameter FRAC_W, default 6: width of the fractional divisor (fraction = baud_divfrac / 2^FRAC_W).
REQ-003 Parameter OVS, default 16: oversample ticks per bit; legal range 2..256; must be even.
REQ-004 CLK  input  1  sole clock; all state updates on posedge.
REQ-005 RSTn  input  1  reset, synchronous, active-low.
REQ-006 enable  input  1  1 = generator runs; 0 = counters held idle.
REQ-007 cfg_valid  input  1  new divisor offered.
REQ-008 cfg_ready  output  1  divisor slot free; a transfer occurs when cfg_valid & cfg_ready.
REQ-009 baud_divint  input  INT_W  integer clocks per oversample tick; 0 is treated as 1.
REQ-010 baud_divfrac  input  FRAC_W  fractional clocks per oversample tick.
REQ-011 ovsTick  output  1  one-CLK pulse per oversample period.
REQ-012 midTick  output  1  one-CLK pulse at bit centre (RX sample point).
REQ-013 bitTick  output  1  one-CLK pulse at bit boundary.
REQ-014 cfg_busy  output  1  a captured divisor is pending and not yet applied.

Function
REQ-015 The block shall hold state: int_count (INT_W+1), target (INT_W+1), acc (FRAC_W), ovs_cnt (ceil(log2 OVS)), active divisor (int, frac), pending divisor plus pending flag.
REQ-016 cfg_ready shall equal !pending, and cfg_busy shall equal pending.
REQ-017 On transfer, baud_divint/baud_divfrac shall be captured into pending and the pending flag set next cycle.
REQ-018 If enable=0 while pending is set, pending shall move to active in the next cycle and the pending flag shall clear.
REQ-019 While enable=1, pending shall move to active only in the cycle bitTick is registered high, with acc cleared and target loaded with the new integer value (min 1) for the next period.
REQ-020 While enable=0, the block shall hold int_count=1, target=max(active int,1), acc=0, ovs_cnt=0, and all ticks 0.
REQ-021 While enable=1, each cycle with int_count >= target shall reset int_count to 1 and register ovsTick=1 for the next cycle; otherwise int_count shall increment and ovsTick=0.
REQ-022 At each terminal count, the block shall compute sum = acc + active frac (FRAC_W+1 bits), set acc <= sum[FRAC_W-1:0], and set target <= max(active int,1) + sum[FRAC_W].
REQ-023 Average ovsTick period shall equal (int + frac/2^FRAC_W) clocks, and no single period shall exceed int+1 clocks.
REQ-024 At each terminal count, ovs_cnt shall advance modulo OVS.
REQ-025 bitTick shall be registered with ovsTick when ovs_cnt == OVS-1, and midTick when ovs_cnt == OVS/2-1.
REQ-026 A transfer and a bitTick in the same cycle shall capture into pending without applying it; application shall occur at the following bitTick.
REQ-027 Deasserting enable mid-bit shall abort the bit, and re-enabling shall start a full bit from ovs_cnt=0.
REQ-028 Outputs shall be pure registers with no combinational path from inputs to ticks; cfg_ready is derived from registered state only.

Reset
REQ-029 With RSTn=0 at posedge, the block shall load int_count=1, target=1, acc=0, ovs_cnt=0, active int=1, active frac=0, pending=0, and all ticks 0.
REQ-030 After reset, cfg_ready=1 and cfg_busy=0; reset mid-operation shall discard any pending divisor.

Verification
REQ-031 Bench: INT_W=16, FRAC_W=6, OVS=16; load int=4, frac=0; enable -> ovsTick every 4 CLK, midTick on the 8th ovsTick, bitTick on every 16th ovsTick (64 CLK period).
REQ-032 Bench: int=2, frac=32; enable -> ovsTick periods 2,2,3,2,3,... with no drift (every 32 ovsTicks = 80 CLK).
REQ-033 Bench: int=0, frac=0 -> ovsTick every CLK; bitTick every 16 CLK.
REQ-034 Bench: running int=4; transfer int=8 mid-bit -> cfg_busy=1 and cfg_ready=0 until bitTick; first post-bitTick ovsTick period = 8; acc=0.
REQ-035 Bench: transfer coincident with bitTick -> new divisor applies at the next bitTick, not this one.
REQ-036 Bench: RSTn=0 for 1 CLK during run with pending set -> all ticks 0, pending cleared, active int=1 next cycle; enable=0 for N cycles -> no ticks, and ovs_cnt restarts at 0.
